// File: rtl/shift_test_sequencer.sv
// Shift-path test sequencer: loads LFSR test words into the shift-out stage, handshakes a
// write then a read through the shift controller, and scores each returned word.
`timescale 1ns/1ps
module shift_test_sequencer #(
    parameter int LOAD_PULSE_CYCLES = 3,
    parameter int TIMEOUT_CYCLES    = 1023
) (
    input  logic        clk,
    input  logic        n_reset,
    input  logic        start,
    input  logic [31:0] pattern_seed,
    input  logic [7:0]  num_words,
    output logic [31:0] load_data,
    output logic        load_data_clk,
    output logic        write_go,
    input  logic        write_ready,
    output logic        read_go,
    input  logic        read_ready,
    input  logic [31:0] read_data,
    output logic        busy,
    output logic        done,
    output logic        pass,
    output logic        timeout,
    output logic [7:0]  error_count,
    output logic [31:0] last_bad_data
);

    typedef enum logic [2:0] {IDLE, LOAD, WGO, WWAIT, RGO, RWAIT, CHECK, DONE} state_t;

    localparam logic [31:0] DEFAULT_SEED = 32'h8F8F_8FE1;
    localparam logic [31:0] LFSR_TAPS    = 32'h8020_0003;
    localparam logic [3:0]  PULSE_LAST   = 4'(LOAD_PULSE_CYCLES - 1);
    localparam logic [15:0] WAIT_LAST    = 16'(TIMEOUT_CYCLES - 1);

    state_t      state_q;
    logic [31:0] pattern_q;
    logic [31:0] pattern_d;
    logic [7:0]  words_q;
    logic [3:0]  pulse_q;
    logic [15:0] wait_q;
    logic [7:0]  error_count_q;
    logic [31:0] last_bad_q;
    logic        timeout_q;
    logic        load_clk_q;
    logic        write_go_q;
    logic        read_go_q;
    logic        wait_expired;

    always_comb begin
        pattern_d = {1'b0, pattern_q[31:1]} ^ (pattern_q[0] ? LFSR_TAPS : 32'h0);
    end

    assign wait_expired = (wait_q == WAIT_LAST);

    // NOTE: sequential state uses non-blocking assignments only, so every register in this
    // block sees the pre-edge value of every other register regardless of statement order.
    always_ff @(posedge clk or negedge n_reset) begin
        if (!n_reset) begin
            state_q       <= IDLE;
            pattern_q     <= '0;
            words_q       <= '0;
            pulse_q       <= '0;
            wait_q        <= '0;
            error_count_q <= '0;
            last_bad_q    <= '0;
            timeout_q     <= 1'b0;
            load_clk_q    <= 1'b0;
            write_go_q    <= 1'b0;
            read_go_q     <= 1'b0;
        end else begin
            // Only the handshake-wait branches count up; any other path, including a state
            // change, leaves the wait counter cleared.
            wait_q <= '0;
            unique case (state_q)
                IDLE, DONE: begin
                    if (start) begin
                        pattern_q     <= (pattern_seed == 32'h0) ? DEFAULT_SEED : pattern_seed;
                        words_q       <= num_words;
                        error_count_q <= '0;
                        last_bad_q    <= '0;
                        timeout_q     <= 1'b0;
                        pulse_q       <= '0;
                        if (num_words == 8'h0) begin
                            state_q <= DONE;
                        end else begin
                            state_q    <= LOAD;
                            load_clk_q <= 1'b1;
                        end
                    end
                end
                LOAD: begin
                    if (load_clk_q) begin
                        if (pulse_q == PULSE_LAST) load_clk_q <= 1'b0;
                        else                       pulse_q    <= pulse_q + 4'd1;
                    end else begin
                        state_q    <= WGO;
                        write_go_q <= 1'b1;
                    end
                end
                WGO: begin
                    if (!write_ready) begin
                        write_go_q <= 1'b0;
                        state_q    <= WWAIT;
                    end else if (wait_expired) begin
                        timeout_q  <= 1'b1;
                        write_go_q <= 1'b0;
                        read_go_q  <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                WWAIT: begin
                    if (write_ready) begin
                        read_go_q <= 1'b1;
                        state_q   <= RGO;
                    end else if (wait_expired) begin
                        timeout_q  <= 1'b1;
                        write_go_q <= 1'b0;
                        read_go_q  <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                RGO: begin
                    if (!read_ready) begin
                        read_go_q <= 1'b0;
                        state_q   <= RWAIT;
                    end else if (wait_expired) begin
                        timeout_q  <= 1'b1;
                        write_go_q <= 1'b0;
                        read_go_q  <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                RWAIT: begin
                    if (read_ready) begin
                        state_q <= CHECK;
                    end else if (wait_expired) begin
                        timeout_q  <= 1'b1;
                        write_go_q <= 1'b0;
                        read_go_q  <= 1'b0;
                        state_q    <= DONE;
                    end else begin
                        wait_q <= wait_q + 16'd1;
                    end
                end
                CHECK: begin
                    if (read_data != pattern_q) begin
                        if (error_count_q != 8'hFF) error_count_q <= error_count_q + 8'd1;
                        last_bad_q <= read_data;
                    end
                    pattern_q <= pattern_d;
                    words_q   <= words_q - 8'd1;
                    pulse_q   <= '0;
                    if (words_q == 8'd1) begin
                        state_q <= DONE;
                    end else begin
                        state_q    <= LOAD;
                        load_clk_q <= 1'b1;
                    end
                end
            endcase
        end
    end

    assign busy          = (state_q != IDLE) && (state_q != DONE);
    assign done          = (state_q == DONE);
    assign pass          = done && (error_count_q == 8'h0) && !timeout_q;
    assign timeout       = timeout_q;
    assign error_count   = error_count_q;
    assign last_bad_data = last_bad_q;
    assign load_data     = busy ? pattern_q : 32'h0;
    assign load_data_clk = load_clk_q;
    assign write_go      = write_go_q;
    assign read_go       = read_go_q;

endmodule

// File: tb/tb_shift_test_sequencer.sv
// Directed bench for shift_test_sequencer: a behavioural shift controller answers the
// go/ready handshakes and loops written words back, optionally corrupted or stuck.
`timescale 1ns/1ps
module tb_shift_test_sequencer;

    logic        clk = 1'b0;
    logic        n_reset = 1'b0;
    logic        start = 1'b0;
    logic [31:0] pattern_seed = '0;
    logic [7:0]  num_words = '0;
    logic [31:0] load_data;
    logic        load_data_clk;
    logic        write_go;
    logic        write_ready = 1'b1;
    logic        read_go;
    logic        read_ready = 1'b1;
    logic [31:0] read_data = '0;
    logic        busy, done, pass, timeout;
    logic [7:0]  error_count;
    logic [31:0] last_bad_data;

    shift_test_sequencer #(
        .LOAD_PULSE_CYCLES(3),
        .TIMEOUT_CYCLES   (1023)
    ) dut (
        .clk          (clk),
        .n_reset      (n_reset),
        .start        (start),
        .pattern_seed (pattern_seed),
        .num_words    (num_words),
        .load_data    (load_data),
        .load_data_clk(load_data_clk),
        .write_go     (write_go),
        .write_ready  (write_ready),
        .read_go      (read_go),
        .read_ready   (read_ready),
        .read_data    (read_data),
        .busy         (busy),
        .done         (done),
        .pass         (pass),
        .timeout      (timeout),
        .error_count  (error_count),
        .last_bad_data(last_bad_data)
    );

    always #5 clk = ~clk;

    // Hand-computed Galois LFSR sequence from 0x8F8F8FE1 with taps 0x80200003.
    logic [31:0] exp_words [4] = '{32'h8F8F_8FE1, 32'hC7E7_C7F3, 32'hE3D3_E3FA, 32'h71E9_F1FD};

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    // Behavioural shift controller.
    bit          stuck_write = 1'b0;
    int          corrupt_idx = -1;
    int          wr_idx = 0;
    int          rd_idx = 0;
    logic [31:0] stored = '0;
    logic [31:0] captured [8];

    initial begin
        forever begin
            @(negedge clk);
            if (write_go && write_ready && !stuck_write) begin
                if (wr_idx < 8) captured[wr_idx] = load_data;
                wr_idx++;
                stored      = load_data;
                write_ready = 1'b0;
                repeat (3) @(negedge clk);
                write_ready = 1'b1;
            end else if (read_go && read_ready) begin
                read_data  = (rd_idx == corrupt_idx) ? (stored ^ 32'h1) : stored;
                rd_idx++;
                read_ready = 1'b0;
                repeat (3) @(negedge clk);
                read_ready = 1'b1;
            end
        end
    end

    // Strobe-width, data-stability and go-exclusivity monitor.
    int          strobes = 0;
    int          hi = 0;
    int          widths [8];
    bit          both_go = 1'b0;
    bit          unstable = 1'b0;
    logic [31:0] strobe_word = '0;

    initial begin
        forever begin
            @(negedge clk);
            if (write_go && read_go) both_go = 1'b1;
            if (load_data_clk) begin
                if (hi == 0) strobe_word = load_data;
                else if (load_data !== strobe_word) unstable = 1'b1;
                hi++;
            end else if (hi != 0) begin
                if (load_data !== strobe_word) unstable = 1'b1;
                if (strobes < 8) widths[strobes] = hi;
                strobes++;
                hi = 0;
            end
        end
    end

    task automatic clear_monitors();
        strobes  = 0;
        wr_idx   = 0;
        rd_idx   = 0;
        both_go  = 1'b0;
        unstable = 1'b0;
    endtask

    task automatic pulse_start(input logic [31:0] seed, input logic [7:0] n);
        @(negedge clk);
        pattern_seed = seed;
        num_words    = n;
        start        = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int n = 0;
        while (!done && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(tag, done, 1);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_data"}, {load_data, last_bad_data}, 64'h0);
        check({tag, "_ctl"}, {load_data_clk, write_go, read_go, busy, done, pass, timeout, error_count}, 64'h0);
    endtask

    initial begin
        int n;

        // Reset state
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        n_reset = 1'b1;

        // num_words == 0 goes straight to DONE with pass
        clear_monitors();
        pulse_start(32'h0000_1234, 8'd0);
        check("zero_done", done, 1);
        check("zero_pass", pass, 1);
        check("zero_busy", busy, 0);
        check("zero_strobes", strobes, 0);

        // Ideal loopback, four words
        clear_monitors();
        pulse_start(32'h8F8F_8FE1, 8'd4);
        check("loop_busy", busy, 1);
        wait_done("loop_done", 2000);
        check("loop_strobes", strobes, 4);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("loop_width%0d", i), widths[i], 3);
            check($sformatf("loop_word%0d", i), captured[i], exp_words[i]);
        end
        check("loop_errors", error_count, 0);
        check("loop_pass", pass, 1);
        check("loop_timeout", timeout, 0);
        check("loop_busy_end", busy, 0);
        check("loop_both_go", both_go, 0);
        check("loop_stable", unstable, 0);

        // Bit 0 of word index 2 inverted on the read path
        clear_monitors();
        corrupt_idx = 2;
        pulse_start(32'h8F8F_8FE1, 8'd4);
        wait_done("bad_done", 2000);
        check("bad_errors", error_count, 1);
        check("bad_last", last_bad_data, 32'hE3D3_E3FB);
        check("bad_pass", pass, 0);
        corrupt_idx = -1;

        // Restart from DONE clears results; then reset in RWAIT
        clear_monitors();
        pulse_start(32'h8F8F_8FE1, 8'd4);
        check("restart_errors", error_count, 0);
        check("restart_last", last_bad_data, 0);
        check("restart_busy", busy, 1);
        n = 0;
        while (!read_go && n < 300) begin
            @(negedge clk);
            n++;
        end
        check("restart_read_go", read_go, 1);
        @(negedge clk);
        check("rwait_busy", busy, 1);
        #2 n_reset = 1'b0;
        #1 check_all_zero("async_reset");
        repeat (5) @(negedge clk);
        n_reset = 1'b1;
        @(negedge clk);
        check("post_reset_idle", {busy, done}, 0);

        // Zero seed substitutes the default pattern
        clear_monitors();
        pulse_start(32'h0, 8'd1);
        n = 0;
        while (!load_data_clk && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("seed0_word", load_data, 32'h8F8F_8FE1);
        wait_done("seed0_done", 500);
        check("seed0_pass", pass, 1);

        // write_ready stuck high: timeout after 1023 cycles in WGO
        clear_monitors();
        stuck_write = 1'b1;
        pulse_start(32'h8F8F_8FE1, 8'd2);
        n = 0;
        while (!write_go && n < 50) begin
            @(negedge clk);
            n++;
        end
        n = 0;
        while (write_go && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check("stuck_go_cycles", n, 1023);
        check("stuck_timeout", timeout, 1);
        check("stuck_write_go", write_go, 0);
        check("stuck_done", done, 1);
        check("stuck_pass", pass, 0);
        check("stuck_busy", busy, 0);
        stuck_write = 1'b0;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
